// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST controller.
// Holds the FSM state encoding and the reference sum function.
package adder_bist_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned NVEC      = 2 ** (2 * DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCheck,
      StDone
   } state_e;

   // Width-generic reference: the result is WIDTH+1 bits wide, zero-extended to 32.
   function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
      return a + b + {31'b0, cin};
   endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Pin bundle between the BIST controller and the adder under test.
interface adder_bist_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             cin_out;
   logic [WIDTH-1:0] sum_in;
   logic             cout_in;

   modport master (
      output a_out, b_out, cin_out,
      input  sum_in, cout_in
   );

   modport slave (
      input  a_out, b_out, cin_out,
      output sum_in, cout_in
   );
endinterface

// File: rtl/bist_sat_counter.sv
// Saturating increment counter with synchronous clear; clear wins over increment.
module bist_sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);
   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !(&count_q)) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test controller for a WIDTH-bit adder: sweeps {cin, b, a}, compares
// the returned sum against a reference and records error count and first failing vector.
module adder_bist
   import adder_bist_pkg::*;
#(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   adder_bist_if.master       adder,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_count,
   output logic               fail_valid,
   output logic [2*WIDTH:0]   fail_vec
);
   localparam int unsigned IW = 2 * WIDTH + 1;
   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CntLoad = CW'(SETTLE_CYCLES - 1);

   state_e          state_q;
   logic [IW-1:0]   idx_q;
   logic [IW-1:0]   fail_vec_q;
   logic [CW-1:0]   cnt_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic            cin_q;
   logic            busy_q, done_q, fail_valid_q;
   logic [31:0]     exp_w;
   logic            mismatch, launch, err_inc;

   assign launch  = start && ((state_q == StIdle) || (state_q == StDone));
   assign err_inc = (state_q == StCheck) && mismatch;

   always_comb begin
      exp_w    = exp_sum(32'(idx_q[WIDTH-1:0]), 32'(idx_q[2*WIDTH-1:WIDTH]), idx_q[2*WIDTH]);
      mismatch = 32'({adder.cout_in, adder.sum_in}) != exp_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         cin_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q          <= StSettle;
                  idx_q            <= '0;
                  cnt_q            <= CntLoad;
                  {cin_q, b_q, a_q} <= '0;
                  busy_q           <= 1'b1;
                  done_q           <= 1'b0;
                  fail_valid_q     <= 1'b0;
                  fail_vec_q       <= '0;
               end
            end
            StSettle: begin
               if (cnt_q == '0) begin
                  state_q <= StCheck;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            StCheck: begin
               if (mismatch && !fail_valid_q) begin
                  fail_valid_q <= 1'b1;
                  fail_vec_q   <= idx_q;
               end
               if (&idx_q) begin
                  state_q          <= StDone;
                  busy_q           <= 1'b0;
                  done_q           <= 1'b1;
                  {cin_q, b_q, a_q} <= '0;
               end else begin
                  state_q          <= StSettle;
                  idx_q            <= idx_q + IW'(1);
                  cnt_q            <= CntLoad;
                  {cin_q, b_q, a_q} <= idx_q + IW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   bist_sat_counter #(
      .Width (ERR_W)
   ) u_err_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (launch),
      .inc_i   (err_inc),
      .count_o (err_count)
   );

   assign adder.a_out   = a_q;
   assign adder.b_out   = b_q;
   assign adder.cin_out = cin_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = done_q && (err_count == '0);
   assign fail_valid    = fail_valid_q;
   assign fail_vec      = fail_vec_q;
endmodule

// File: tb/tb_adder_bist.sv
// Randomised bench for adder_bist: a behavioural adder with selectable faults, checked
// against error statistics derived directly from the vector space.
module tb_adder_bist;
   localparam int NV      = 512;
   localparam int LASTE   = NV * 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass, fail_valid;
   logic [7:0] err_count;
   logic [8:0] fail_vec;
   int         mode = 0;
   logic [4:0] flip_mask [NV];
   int         checks = 0;
   int         failures = 0;

   adder_bist_if #(.WIDTH(4)) bus ();

   adder_bist #(
      .WIDTH         (4),
      .SETTLE_CYCLES (2),
      .ERR_W         (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .adder      (bus),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_vec   (fail_vec)
   );

   always #5 clk = ~clk;

   // Adder under test: mode 0 good, 1 sum[0] stuck low, 2 all bits inverted, 3 random flips.
   function automatic logic [4:0] adder_model(input int m, input int v);
      logic [4:0] good;
      good = 5'(v % 16) + 5'((v / 16) % 16) + 5'(v / 256);
      case (m)
         1:       return good & 5'b11110;
         2:       return ~good;
         3:       return good ^ flip_mask[v];
         default: return good;
      endcase
   endfunction

   always_comb begin
      {bus.cout_in, bus.sum_in} = adder_model(mode, int'({bus.cin_out, bus.b_out, bus.a_out}));
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
      check_eq({tag, "_pass"}, 32'(pass), 0);
      check_eq({tag, "_err"}, 32'(err_count), 0);
      check_eq({tag, "_fvalid"}, 32'(fail_valid), 0);
      check_eq({tag, "_fvec"}, 32'(fail_vec), 0);
      check_eq({tag, "_drive"}, 32'({bus.cin_out, bus.b_out, bus.a_out}), 0);
   endtask

   // Runs one sweep; rst_at > 0 aborts with a reset at that edge, repulse_at > 0 re-pulses start.
   task automatic run_sweep(input string tag, input int m, input int rst_at, input int repulse_at);
      int nerr = 0;
      int first = -1;
      int rnd;
      logic [4:0] want;
      mode = m;
      for (int v = 0; v < NV; v++) begin
         want = 5'(v % 16) + 5'((v / 16) % 16) + 5'(v / 256);
         if (adder_model(m, v) != want) begin
            nerr++;
            if (first < 0) first = v;
         end
      end
      rnd = $urandom_range(4, LASTE - 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= LASTE; n++) begin
         @(posedge clk);
         #1;
         if (n == rst_at) begin
            rst = 1'b1;
            #1 check_all_zero({tag, "_midrst"});
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (n == repulse_at) start = 1'b1;
         if (n == repulse_at + 1) start = 1'b0;
         if (n == 1 || n == rnd || n == LASTE - 1) begin
            check_eq({tag, "_busy"}, 32'(busy), 1);
            check_eq({tag, "_done_early"}, 32'(done), 0);
            check_eq({tag, "_drive"}, 32'({bus.cin_out, bus.b_out, bus.a_out}), 32'(n / 3));
         end
      end
      check_eq({tag, "_busy_end"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 1);
      check_eq({tag, "_err"}, 32'(err_count), 32'((nerr > 255) ? 255 : nerr));
      check_eq({tag, "_pass"}, 32'(pass), 32'(nerr == 0));
      check_eq({tag, "_fvalid"}, 32'(fail_valid), 32'(nerr > 0));
      check_eq({tag, "_fvec"}, 32'(fail_vec), 32'((first < 0) ? 0 : first));
      check_eq({tag, "_drive_end"}, 32'({bus.cin_out, bus.b_out, bus.a_out}), 0);
      repeat (2) @(posedge clk);
      #1 check_eq({tag, "_done_held"}, 32'(done), 1);
   endtask

   task automatic fill_masks(input int density);
      for (int i = 0; i < NV; i++) begin
         flip_mask[i] = ($urandom_range(0, density - 1) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      end
   endtask

   initial begin
      fill_masks(8);
      #12;
      check_all_zero("reset_held");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check_all_zero("reset_released");

      run_sweep("good", 0, 0, 0);
      run_sweep("sum0_stuck", 1, 0, 0);
      run_sweep("inverted", 2, 0, 400);
      run_sweep("rand_a", 3, 0, 0);
      fill_masks(64);
      run_sweep("rand_b", 3, 0, 400);
      run_sweep("abort", 3, 700, 0);
      run_sweep("after_rst", 0, 0, 0);
      run_sweep("rerun", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
